// File: rtl/core_rrv_muldiv_pkg.sv
// Shared types and constants for the rrv M-extension multiply/divide unit.
// Provides:
//   t_muldiv_op    - operation encoding, identical to the RISC-V M funct3 field
//   t_muldiv_state - control FSM states of core_rrv_muldiv
//   MULDIV_FUNCT7 / OPCODE_OP - decode constants reused by core_rrv_ctrl
//   small helpers that classify an operation from its funct3 bits
package core_rrv_muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } t_muldiv_op;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DONE     = 3'd4
    } t_muldiv_state;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic opIsDiv(input t_muldiv_op op);
        return op[2];
    endfunction

    // DIV and REM (funct3[0]==0) treat their operands as signed
    function automatic logic opIsSignedDiv(input t_muldiv_op op);
        return ~op[0];
    endfunction

    // REM/REMU return the remainder instead of the quotient
    function automatic logic opIsRem(input t_muldiv_op op);
        return op[1];
    endfunction

endpackage

// File: rtl/core_rrv_div_iter.sv
// Iterative restoring divider datapath, one quotient bit per clock.
// Operates on unsigned magnitudes; sign handling lives in the parent.
// Ports:
//   Clock, Rst            - core clock, asynchronous active-high reset
//   Start                 - load Dividend/Divisor and begin XLEN iterations
//   Kill                  - abandon any running division
//   Dividend, Divisor     - unsigned operands, sampled on Start
//   Quotient, Remainder   - results, valid once the iterations have finished
//   Done                  - high during the cycle whose clock edge performs
//                           the final iteration
module core_rrv_div_iter
    import core_rrv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            Start,
    input  logic            Kill,
    input  logic [XLEN-1:0] Dividend,
    input  logic [XLEN-1:0] Divisor,
    output logic [XLEN-1:0] Quotient,
    output logic [XLEN-1:0] Remainder,
    output logic            Done
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  remR;
    logic [XLEN-1:0]  quoR;
    logic [XLEN-1:0]  divR;
    logic [CNT_W-1:0] cntR;
    logic [XLEN:0]    shiftedS;
    logic [XLEN:0]    diffS;
    logic [XLEN-1:0]  remNextS;
    logic [XLEN-1:0]  quoNextS;
    logic             activeS;

    assign activeS   = (cntR != '0);
    assign Done      = activeS && (cntR == CNT_W'(1));
    assign Quotient  = quoR;
    assign Remainder = remR;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        shiftedS = {remR, quoR[XLEN-1]};
        diffS    = shiftedS - {1'b0, divR};
        remNextS = shiftedS[XLEN-1:0];
        quoNextS = {quoR[XLEN-2:0], 1'b0};
        if (diffS[XLEN]) begin
            remNextS = shiftedS[XLEN-1:0];
            quoNextS = {quoR[XLEN-2:0], 1'b0};
        end else begin
            remNextS = diffS[XLEN-1:0];
            quoNextS = {quoR[XLEN-2:0], 1'b1};
        end
    end

    // Shift registers and iteration counter; the dividend shifts out of quoR as quotient bits shift in
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            remR <= '0;
            quoR <= '0;
            divR <= '0;
            cntR <= '0;
        end else if (Kill) begin
            cntR <= '0;
        end else if (Start) begin
            remR <= '0;
            quoR <= Dividend;
            divR <= Divisor;
            cntR <= CNT_W'(XLEN);
        end else if (activeS) begin
            remR <= remNextS;
            quoR <= quoNextS;
            cntR <= cntR - CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_rrv_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the Q102H ALU.
// Multiplies complete MUL_LATENCY cycles after acceptance; divides take
// XLEN+2 cycles (abs values at accept, XLEN iterations, sign fix-up), except
// divide-by-zero and signed overflow which answer the next cycle.
// Ports:
//   Clock, Rst                      - core clock, async active-high reset
//   ReqValidQ102H / ReqReadyQ102H   - request handshake
//   Funct3Q102H, Rs1DataQ102H,
//   Rs2DataQ102H, RdQ102H           - operation, operands, destination tag
//   Kill                            - flush in-flight / pending operation
//   RspValid / RspReady             - response handshake
//   RspData, RspRd                  - result and its destination tag
//   Busy                            - unit not idle (hazard detection)
module core_rrv_muldiv
    import core_rrv_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int RF_NUM_MSB  = 4
) (
    input  logic                Clock,
    input  logic                Rst,
    input  logic                ReqValidQ102H,
    output logic                ReqReadyQ102H,
    input  logic [2:0]          Funct3Q102H,
    input  logic [XLEN-1:0]     Rs1DataQ102H,
    input  logic [XLEN-1:0]     Rs2DataQ102H,
    input  logic [RF_NUM_MSB:0] RdQ102H,
    input  logic                Kill,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [XLEN-1:0]     RspData,
    output logic [RF_NUM_MSB:0] RspRd,
    output logic                Busy
);

    localparam int MUL_CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam t_muldiv_state MUL_FIRST_STATE = (MUL_LATENCY == 1) ? DONE : MUL_WAIT;

    t_muldiv_state          stateR;
    t_muldiv_state          nextStateS;
    t_muldiv_op             reqOpS;
    logic                   acceptS;
    logic                   reqIsDivS;
    logic                   divZeroS;
    logic                   divOvfS;
    logic                   fastS;
    logic                   aNegS;
    logic                   bNegS;
    logic [XLEN-1:0]        absAS;
    logic [XLEN-1:0]        absBS;
    logic [XLEN-1:0]        fastResultS;
    logic [2*XLEN-1:0]      mulAS;
    logic [2*XLEN-1:0]      mulBS;
    logic [2*XLEN-1:0]      productS;
    logic [XLEN-1:0]        mulSelS;
    logic [XLEN-1:0]        divQuoS;
    logic [XLEN-1:0]        divRemS;
    logic                   divDoneS;
    logic [XLEN-1:0]        fixResultS;
    logic [XLEN-1:0]        rspNextS;
    logic                   loadRspS;
    logic [MUL_CNT_W-1:0]   mulCntR;
    logic [XLEN-1:0]        mulResultR;
    logic [XLEN-1:0]        rspDataR;
    logic [RF_NUM_MSB:0]    rdR;
    logic                   isRemR;
    logic                   negQuoR;
    logic                   negRemR;

    assign reqOpS        = t_muldiv_op'(Funct3Q102H);
    assign ReqReadyQ102H = (stateR == IDLE) || ((stateR == DONE) && RspReady);
    assign acceptS       = ReqValidQ102H && ReqReadyQ102H && !Kill;
    assign RspValid      = (stateR == DONE);
    assign Busy          = (stateR != IDLE);
    assign RspData       = rspDataR;
    assign RspRd         = rdR;

    // Request decode: fast-path detection, absolute values and the multiplier array
    always_comb begin
        reqIsDivS = opIsDiv(reqOpS);
        divZeroS  = (Rs2DataQ102H == '0);
        divOvfS   = opIsSignedDiv(reqOpS)
                    && (Rs1DataQ102H == {1'b1, {(XLEN-1){1'b0}}})
                    && (Rs2DataQ102H == '1);
        fastS     = divZeroS || divOvfS;
        aNegS     = opIsSignedDiv(reqOpS) && Rs1DataQ102H[XLEN-1];
        bNegS     = opIsSignedDiv(reqOpS) && Rs2DataQ102H[XLEN-1];
        absAS     = aNegS ? ('0 - Rs1DataQ102H) : Rs1DataQ102H;
        absBS     = bNegS ? ('0 - Rs2DataQ102H) : Rs2DataQ102H;
        if (divZeroS) begin
            fastResultS = opIsRem(reqOpS) ? Rs1DataQ102H : '1;
        end else begin
            fastResultS = opIsRem(reqOpS) ? '0 : Rs1DataQ102H;
        end
        // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MULH; sign-extending
        // to 2*XLEN makes the low 2*XLEN product bits exact for every mix
        mulAS    = {{XLEN{(reqOpS[1:0] != 2'b11) && Rs1DataQ102H[XLEN-1]}}, Rs1DataQ102H};
        mulBS    = {{XLEN{(reqOpS[1:0] == 2'b01) && Rs2DataQ102H[XLEN-1]}}, Rs2DataQ102H};
        productS = mulAS * mulBS;
        mulSelS  = (reqOpS[1:0] == 2'b00) ? productS[XLEN-1:0] : productS[2*XLEN-1:XLEN];
    end

    core_rrv_div_iter #(
        .XLEN(XLEN)
    ) uDivIter (
        .Clock     (Clock),
        .Rst       (Rst),
        .Start     (acceptS && reqIsDivS && !fastS),
        .Kill      (Kill),
        .Dividend  (absAS),
        .Divisor   (absBS),
        .Quotient  (divQuoS),
        .Remainder (divRemS),
        .Done      (divDoneS)
    );

    // Sign fix-up of the unsigned divider result
    always_comb begin
        if (isRemR) begin
            fixResultS = negRemR ? ('0 - divRemS) : divRemS;
        end else begin
            fixResultS = negQuoR ? ('0 - divQuoS) : divQuoS;
        end
    end

    // Next-state logic: Kill first, then a new accept, then normal sequencing
    always_comb begin
        nextStateS = stateR;
        if (Kill) begin
            nextStateS = IDLE;
        end else if (acceptS) begin
            if (reqIsDivS) begin
                nextStateS = fastS ? DONE : DIV_RUN;
            end else begin
                nextStateS = MUL_FIRST_STATE;
            end
        end else begin
            case (stateR)
                IDLE:     nextStateS = IDLE;
                MUL_WAIT: nextStateS = (mulCntR == '0) ? DONE : MUL_WAIT;
                DIV_RUN:  nextStateS = divDoneS ? DIV_FIX : DIV_RUN;
                DIV_FIX:  nextStateS = DONE;
                DONE:     nextStateS = RspReady ? IDLE : DONE;
                default:  nextStateS = IDLE;
            endcase
        end
    end

    // Response data source, loaded only on entry into DONE so a stalled result stays put
    always_comb begin
        loadRspS = (nextStateS == DONE) && ((stateR != DONE) || acceptS);
        case (stateR)
            MUL_WAIT: rspNextS = mulResultR;
            DIV_FIX:  rspNextS = fixResultS;
            default:  rspNextS = reqIsDivS ? fastResultS : mulSelS;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Operation context captured at accept, multiply latency counter and response register
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            mulCntR    <= '0;
            mulResultR <= '0;
            rspDataR   <= '0;
            rdR        <= '0;
            isRemR     <= 1'b0;
            negQuoR    <= 1'b0;
            negRemR    <= 1'b0;
        end else begin
            if (acceptS) begin
                rdR        <= RdQ102H;
                isRemR     <= opIsRem(reqOpS);
                negQuoR    <= aNegS ^ bNegS;
                negRemR    <= aNegS;
                mulResultR <= mulSelS;
                mulCntR    <= MUL_CNT_W'(MUL_LATENCY - 2);
            end else if ((stateR == MUL_WAIT) && (mulCntR != '0)) begin
                mulCntR <= mulCntR - MUL_CNT_W'(1);
            end
            if (loadRspS) begin
                rspDataR <= rspNextS;
            end
        end
    end

endmodule

// File: tb/tb_core_rrv_muldiv.sv
// Directed self-checking bench for core_rrv_muldiv (XLEN=32, MUL_LATENCY=2).
module tb_core_rrv_muldiv;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 2;
    localparam int RF_NUM_MSB  = 4;

    logic                Clock = 1'b0;
    logic                Rst   = 1'b1;
    logic                ReqValidQ102H;
    logic                ReqReadyQ102H;
    logic [2:0]          Funct3Q102H;
    logic [XLEN-1:0]     Rs1DataQ102H;
    logic [XLEN-1:0]     Rs2DataQ102H;
    logic [RF_NUM_MSB:0] RdQ102H;
    logic                Kill;
    logic                RspValid;
    logic                RspReady;
    logic [XLEN-1:0]     RspData;
    logic [RF_NUM_MSB:0] RspRd;
    logic                Busy;

    int checks = 0;
    int errors = 0;

    core_rrv_muldiv #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY),
        .RF_NUM_MSB  (RF_NUM_MSB)
    ) dut (
        .Clock         (Clock),
        .Rst           (Rst),
        .ReqValidQ102H (ReqValidQ102H),
        .ReqReadyQ102H (ReqReadyQ102H),
        .Funct3Q102H   (Funct3Q102H),
        .Rs1DataQ102H  (Rs1DataQ102H),
        .Rs2DataQ102H  (Rs2DataQ102H),
        .RdQ102H       (RdQ102H),
        .Kill          (Kill),
        .RspValid      (RspValid),
        .RspReady      (RspReady),
        .RspData       (RspData),
        .RspRd         (RspRd),
        .Busy          (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE at a negedge, measure latency to RspValid, check result, consume it
    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int expLat,
                         input logic [31:0] expData);
        int lat;
        check({tag, "_ready"}, 64'(ReqReadyQ102H), 64'd1);
        ReqValidQ102H = 1'b1;
        Funct3Q102H   = f3;
        Rs1DataQ102H  = a;
        Rs2DataQ102H  = b;
        RdQ102H       = rd;
        @(posedge Clock);
        @(negedge Clock);
        ReqValidQ102H = 1'b0;
        lat = 1;
        while (!RspValid && lat < 100) begin
            @(negedge Clock);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(expLat));
        check({tag, "_data"}, 64'(RspData), 64'(expData));
        check({tag, "_rd"}, 64'(RspRd), 64'(rd));
        @(negedge Clock);
        check({tag, "_idle"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int seen;
        ReqValidQ102H = 1'b0;
        Funct3Q102H   = 3'b000;
        Rs1DataQ102H  = 32'd0;
        Rs2DataQ102H  = 32'd0;
        RdQ102H       = 5'd0;
        Kill          = 1'b0;
        RspReady      = 1'b1;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_valid", 64'(RspValid), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_data", 64'(RspData), 64'd0);
        check("rst_rd", 64'(RspRd), 64'd0);
        Rst = 1'b0;
        @(negedge Clock);
        check("rst_ready", 64'(ReqReadyQ102H), 64'd1);

        // Multiplies
        runOp("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 2, 32'hFFFFFFEB);
        runOp("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd2, 2, 32'h40000000);
        runOp("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 2, 32'hFFFFFFFE);
        runOp("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 2, 32'hFFFFFFFF);

        // Iterative divides
        runOp("div",    3'b100, 32'hFFFFFFEC, 32'd3,        5'd5,  34, 32'hFFFFFFFA);
        runOp("rem",    3'b110, 32'hFFFFFFEC, 32'd3,        5'd6,  34, 32'hFFFFFFFE);
        runOp("divu",   3'b101, 32'd100,      32'd7,        5'd7,  34, 32'd14);
        runOp("remu",   3'b111, 32'd100,      32'd7,        5'd8,  34, 32'd2);
        runOp("div_nb", 3'b100, 32'd20,       32'hFFFFFFFD, 5'd9,  34, 32'hFFFFFFFA);
        runOp("rem_nb", 3'b110, 32'd20,       32'hFFFFFFFD, 5'd10, 34, 32'd2);

        // Fast paths
        runOp("divu_z", 3'b101, 32'd5,        32'd0,        5'd11, 1, 32'hFFFFFFFF);
        runOp("rem_z",  3'b110, 32'd5,        32'd0,        5'd12, 1, 32'd5);
        runOp("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 1, 32'h80000000);
        runOp("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 1, 32'd0);

        // Back-pressure: MUL 7*3 held for 5 cycles while MUL 6*7 waits at the input
        RspReady      = 1'b0;
        ReqValidQ102H = 1'b1;
        Funct3Q102H   = 3'b000;
        Rs1DataQ102H  = 32'd7;
        Rs2DataQ102H  = 32'd3;
        RdQ102H       = 5'd15;
        @(posedge Clock);
        @(negedge Clock);
        Rs1DataQ102H  = 32'd6;
        Rs2DataQ102H  = 32'd7;
        RdQ102H       = 5'd16;
        check("bp_t1_valid", 64'(RspValid), 64'd0);
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(RspValid), 64'd1);
            check("bp_data", 64'(RspData), 64'd21);
            check("bp_rd", 64'(RspRd), 64'd15);
            check("bp_ready", 64'(ReqReadyQ102H), 64'd0);
            @(negedge Clock);
        end
        RspReady = 1'b1;
        #1;
        check("bp_release_ready", 64'(ReqReadyQ102H), 64'd1);
        @(posedge Clock);
        @(negedge Clock);
        ReqValidQ102H = 1'b0;
        check("bp2_t1_valid", 64'(RspValid), 64'd0);
        check("bp2_t1_busy", 64'(Busy), 64'd1);
        @(negedge Clock);
        check("bp2_valid", 64'(RspValid), 64'd1);
        check("bp2_data", 64'(RspData), 64'd42);
        check("bp2_rd", 64'(RspRd), 64'd16);
        @(negedge Clock);
        check("bp2_idle", 64'(Busy), 64'd0);

        // Kill at T+10 of a DIVU
        ReqValidQ102H = 1'b1;
        Funct3Q102H   = 3'b101;
        Rs1DataQ102H  = 32'd100;
        Rs2DataQ102H  = 32'd7;
        RdQ102H       = 5'd17;
        @(posedge Clock);
        @(negedge Clock);
        ReqValidQ102H = 1'b0;
        repeat (9) @(negedge Clock);
        check("kill_pre_busy", 64'(Busy), 64'd1);
        check("kill_pre_ready", 64'(ReqReadyQ102H), 64'd0);
        Kill = 1'b1;
        @(negedge Clock);
        Kill = 1'b0;
        check("kill_ready", 64'(ReqReadyQ102H), 64'd1);
        check("kill_busy", 64'(Busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge Clock);
            if (RspValid) seen++;
        end
        check("kill_no_rsp", 64'(seen), 64'd0);

        // Kill concurrent with a request in IDLE
        ReqValidQ102H = 1'b1;
        Kill          = 1'b1;
        Funct3Q102H   = 3'b000;
        Rs1DataQ102H  = 32'd2;
        Rs2DataQ102H  = 32'd2;
        RdQ102H       = 5'd18;
        @(posedge Clock);
        @(negedge Clock);
        ReqValidQ102H = 1'b0;
        Kill          = 1'b0;
        check("killreq_busy1", 64'(Busy), 64'd0);
        @(negedge Clock);
        check("killreq_busy2", 64'(Busy), 64'd0);
        check("killreq_valid", 64'(RspValid), 64'd0);

        // Async reset pulse mid-divide
        ReqValidQ102H = 1'b1;
        Funct3Q102H   = 3'b100;
        Rs1DataQ102H  = 32'hFFFFFFEC;
        Rs2DataQ102H  = 32'd3;
        RdQ102H       = 5'd19;
        @(posedge Clock);
        @(negedge Clock);
        ReqValidQ102H = 1'b0;
        repeat (5) @(negedge Clock);
        check("arst_pre_busy", 64'(Busy), 64'd1);
        #2;
        Rst = 1'b1;
        #1;
        check("arst_valid", 64'(RspValid), 64'd0);
        check("arst_busy", 64'(Busy), 64'd0);
        @(negedge Clock);
        Rst = 1'b0;
        @(negedge Clock);
        runOp("divu_post", 3'b101, 32'd9, 32'd3, 5'd20, 34, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_rrv_muldiv.md
Name: core_rrv_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit that adds RV32M/RV64M execution to the rrv pipeline. It sits beside the Q102H ALU.
- Accepts one operation per handshake and runs multiplies through a configurable-latency path and divides through an iterative 1-bit/cycle radix-2 engine.
- Returns the result with a valid/ready handshake, so the pipeline control can back-pressure Q102H/Q103H.
- Supports flush (kill) on branch/interrupt redirect.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LATENCY, 2, cycles from accept to RspValid for MUL* ops (minimum 1).
- RF_NUM_MSB, 4, MSB of destination register tag (4 = 32 regs, 3 = RV32E).

Ports:
- Clock  in  1  core clock.
- Rst  in  1  asynchronous, active-high reset.
- ReqValidQ102H  in  1  operation request valid.
- ReqReadyQ102H  out  1  unit can accept a request this cycle.
- Funct3Q102H  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Rs1DataQ102H  in  XLEN  operand A (dividend/multiplicand).
- Rs2DataQ102H  in  XLEN  operand B (divisor/multiplier).
- RdQ102H  in  RF_NUM_MSB+1  destination register tag, returned with the result.
- Kill  in  1  flush; discards any in-flight or pending-response operation.
- RspValid  out  1  result valid.
- RspReady  in  1  consumer accepts the result.
- RspData  out  XLEN  result.
- RspRd  out  RF_NUM_MSB+1  destination tag of the result.
- Busy  out  1  operation in flight or response pending (for hazard detection).

Behaviour:
- Reset (async, Rst=1): state=IDLE; RspValid=0, RspData=0, RspRd=0, Busy=0; counters and divider registers 0. ReqReadyQ102H=1 once out of reset.
- Accept: ReqValidQ102H && ReqReadyQ102H && !Kill at rising edge (cycle T). Operands, funct3 and tag are latched at T.
- ReqReadyQ102H = (state==IDLE) || (state==DONE && RspReady). Back-to-back operations are allowed the cycle a response is consumed.
- States:
  - IDLE -> MUL_WAIT on a MUL* accept.
  - IDLE -> DIV_RUN on a DIV* accept.
  - IDLE -> DONE on a divide fast-path accept.
  - MUL_WAIT -> DONE after MUL_LATENCY-1 further cycles.
  - DIV_RUN -> DIV_FIX after XLEN iterations.
  - DIV_FIX -> DONE.
  - DONE -> IDLE on RspReady, or to MUL_WAIT/DIV_RUN/DONE on a simultaneous new accept.
- RspValid = (state==DONE). MUL: RspValid at T+MUL_LATENCY. DIV/REM normal: RspValid at T+XLEN+2 (1 setup cycle computes abs values, XLEN iterations, 1 sign fix-up cycle).
- Multiply: product is 2*XLEN bits. MUL returns low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both operands unsigned.
  - Sign handling uses XLEN+1-bit sign-extended operands.
- Divide: restoring, unsigned magnitudes. Quotient sign = sign(A) XOR sign(B) for DIV. Remainder takes the sign of the dividend for REM.
- Fast path (RspValid at T+1, no iteration):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow, DIV/REM with A = most-negative and B = -1: quotient = A; remainder = 0.
- RspData/RspRd are held stable while RspValid && !RspReady. No new request is accepted in that state.
- Kill has priority over everything:
  - Next state is IDLE, RspValid drops next cycle, and the result is discarded.
  - A request presented in the same cycle as Kill is not accepted.
  - Kill while IDLE has no effect.
- Busy = (state != IDLE).
- Rst asserted mid-operation returns to IDLE immediately. No response is ever produced for the aborted operation.

Decomposition:
- common_pkg gets:
  - t_muldiv_op enum matching funct3 encoding.
  - t_muldiv_state enum {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE}.
  - Localparams MULDIV_FUNCT7 = 7'b0000001 and the OPCODE_OP reuse for decode in core_rrv_ctrl.
- Sub-module core_rrv_div_iter holds the iterative restoring divider datapath:
  - Remainder/quotient shift registers.
  - Log2(XLEN)+1 iteration counter.
  - Start/done pulse.
- The FSM, multiplier and sign fix-up stay in the top.

Test Plan (XLEN=32, MUL_LATENCY=2):
- MUL 7 * 0xFFFFFFFD -> RspData 0xFFFFFFEB, RspValid at T+2. MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA at T+34. REM same operands -> 0xFFFFFFFE. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. RspRd equals the tag sent.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5 at T+1. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both at T+1.
- Back-pressure: hold RspReady=0 for 5 cycles after RspValid -> RspData/RspRd stable, ReqReadyQ102H=0. Then RspReady=1 with a new MUL request in the same cycle -> accepted, next result at +2.
- Kill at T+10 during a DIV -> no RspValid ever for it, ReqReadyQ102H=1 at T+11. Kill concurrent with ReqValidQ102H in IDLE -> request not accepted, Busy stays 0.
- Async Rst pulse mid-DIV (between clock edges) -> RspValid/Busy=0 immediately. After release, a fresh DIVU 9/3 -> 3 at T+34.
